// File: rtl/param_stack_if.sv
// Command/response handshake bundle for param_stack: a valid/ready command
// channel into the stack and a valid/ready response channel back out.
interface param_stack_if #(
  parameter int WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO stack with PEEK/PUSH/POP/REPLACE over valid/ready channels.
// Optional running XOR checksum of the valid entries: define PARAM_STACK_CHECKSUM_EN.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  param_stack_if.slave           bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf_sticky,
  output logic                   unf_sticky,
  input  logic                   clr_flags,
  output logic [WIDTH-1:0]       checksum
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    OP_PEEK    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [AW:0]      count_q, count_nxt;
  logic [WIDTH-1:0] rsp_data_q, res_data;
  logic             rsp_err_q, res_err;
  logic             ovf_q, unf_q, ovf_set, unf_set;
  logic             cmd_ready, rsp_valid, accept;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx, push_idx;
  logic [WIDTH-1:0] top_data;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign push_idx = count_q[AW-1:0];
  assign top_idx  = AW'(count_q - CNT_ONE);
  assign top_data = mem[top_idx];
  assign accept   = bus.cmd_valid & cmd_ready;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operation decode; everything here is quiet outside EXEC.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    count_nxt = count_q;
    res_data  = '0;
    res_err   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (state == EXEC) begin
      case (op_q)
        OP_PUSH: begin
          if (is_full) begin
            res_err = 1'b1;
            ovf_set = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = push_idx;
            count_nxt = count_q + CNT_ONE;
            res_data  = data_q;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            res_err = 1'b1;
            unf_set = 1'b1;
          end else begin
            res_data  = top_data;
            count_nxt = count_q - CNT_ONE;
          end
        end
        OP_PEEK: begin
          if (is_empty) begin
            res_err = 1'b1;
            unf_set = 1'b1;
          end else begin
            res_data = top_data;
          end
        end
        OP_REPLACE: begin
          if (is_empty) begin
            res_err = 1'b1;
            unf_set = 1'b1;
          end else begin
            res_data  = top_data;
            mem_we    = 1'b1;
            mem_waddr = top_idx;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == EXEC) begin
        count_q    <= count_nxt;
        rsp_data_q <= res_data;
        rsp_err_q  <= res_err;
      end
      // A flag being set outranks a simultaneous clear request.
      ovf_q <= ovf_set | (ovf_q & ~clr_flags);
      unf_q <= unf_set | (unf_q & ~clr_flags);
    end
  end

  // NOTE: storage and the latched command carry no reset; nothing is read from
  // them before count/state make it valid, and a write is suppressed under rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_e'(bus.cmd_op);
      data_q <= bus.cmd_data;
    end
    if (mem_we && !rst) mem[mem_waddr] <= data_q;
  end

`ifdef PARAM_STACK_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_delta;

  always_comb begin
    csum_delta = '0;
    if (state == EXEC && !res_err) begin
      case (op_q)
        OP_PUSH:    csum_delta = data_q;
        OP_POP:     csum_delta = top_data;
        OP_REPLACE: csum_delta = top_data ^ data_q;
        OP_PEEK:    csum_delta = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_q ^ csum_delta;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack (WIDTH=8, DEPTH=4); inputs driven and outputs
// sampled on the falling edge.
module tb_param_stack;

  localparam logic [1:0] OP_PEEK = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_REPLACE = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_flags = 1'b0;
  logic [2:0] count;
  logic       empty, full, ovf_sticky, unf_sticky;
  logic [7:0] checksum;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] r_data;
  logic       r_err;
  logic [2:0] r_count;
  logic       r_unf;

  param_stack_if #(.WIDTH(8)) bus ();

  param_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky),
    .clr_flags  (clr_flags),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    clr_flags = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction; the response is captured the first falling edge
  // rsp_valid is seen, then consumed on the next rising edge.
  task automatic do_op(input logic [1:0] op, input logic [7:0] data);
    bit ok;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.rsp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      $display("FAIL accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
      n_mis++;
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
      n_mis++;
      return;
    end
    r_data  = bus.rsp_data;
    r_err   = bus.rsp_err;
    r_count = count;
    r_unf   = unf_sticky;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    if (count !== 3'd0) begin $display("FAIL rst_count got=%0d exp=0", count); n_mis++; end
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0) begin $display("FAIL rst_empty_full got=%b%b exp=10", empty, full); n_mis++; end
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 8'h00) begin
      $display("FAIL rst_rsp got v=%b e=%b d=%h exp v=0 e=0 d=00", bus.rsp_valid, bus.rsp_err, bus.rsp_data); n_mis++;
    end
    n_cmp++;
    if (ovf_sticky !== 1'b0 || unf_sticky !== 1'b0) begin $display("FAIL rst_sticky got=%b%b exp=00", ovf_sticky, unf_sticky); n_mis++; end
    n_cmp++;
    if (checksum !== 8'h00) begin $display("FAIL rst_checksum got=%h exp=00", checksum); n_mis++; end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_push_pop();
    logic [1:0] ops  [4] = '{OP_PUSH, OP_PUSH, OP_POP, OP_POP};
    logic [7:0] din  [4] = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    logic [7:0] dexp [4] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
    logic [2:0] cexp [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], din[i]);
      if (r_data !== dexp[i] || r_err !== 1'b0 || r_count !== cexp[i]) begin
        $display("FAIL push_pop[%0d] got d=%h e=%b c=%0d exp d=%h e=0 c=%0d", i, r_data, r_err, r_count, dexp[i], cexp[i]);
        n_mis++;
      end
      n_cmp++;
    end
    if (empty !== 1'b1) begin $display("FAIL push_pop_empty got=%b exp=1", empty); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 8'(i));
    if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
      $display("FAIL full_state got full=%b count=%0d empty=%b exp 1 4 0", full, count, empty); n_mis++;
    end
    n_cmp++;
    do_op(OP_PEEK, 8'h00);
    if (r_data !== 8'h04 || r_err !== 1'b0 || r_count !== 3'd4) begin
      $display("FAIL full_peek got d=%h e=%b c=%0d exp 04 0 4", r_data, r_err, r_count); n_mis++;
    end
    n_cmp++;
    do_op(OP_PUSH, 8'h55);
    if (r_data !== 8'h00 || r_err !== 1'b1 || r_count !== 3'd4) begin
      $display("FAIL full_push got d=%h e=%b c=%0d exp 00 1 4", r_data, r_err, r_count); n_mis++;
    end
    n_cmp++;
    if (ovf_sticky !== 1'b1 || unf_sticky !== 1'b0) begin $display("FAIL full_ovf got=%b%b exp=10", ovf_sticky, unf_sticky); n_mis++; end
    n_cmp++;
    do_op(OP_POP, 8'h00);
    if (r_data !== 8'h04 || r_err !== 1'b0 || r_count !== 3'd3) begin
      $display("FAIL full_pop got d=%h e=%b c=%0d exp 04 0 3", r_data, r_err, r_count); n_mis++;
    end
    n_cmp++;
  endtask

  task automatic test_underflow();
    apply_reset();
    do_op(OP_POP, 8'h00);
    if (r_data !== 8'h00 || r_err !== 1'b1 || r_count !== 3'd0 || unf_sticky !== 1'b1) begin
      $display("FAIL unf_pop got d=%h e=%b c=%0d unf=%b exp 00 1 0 1", r_data, r_err, r_count, unf_sticky); n_mis++;
    end
    n_cmp++;
    do_op(OP_PEEK, 8'h00);
    if (r_data !== 8'h00 || r_err !== 1'b1 || unf_sticky !== 1'b1) begin
      $display("FAIL unf_peek got d=%h e=%b unf=%b exp 00 1 1", r_data, r_err, unf_sticky); n_mis++;
    end
    n_cmp++;
    do_op(OP_REPLACE, 8'h77);
    if (r_data !== 8'h00 || r_err !== 1'b1 || r_count !== 3'd0) begin
      $display("FAIL unf_replace got d=%h e=%b c=%0d exp 00 1 0", r_data, r_err, r_count); n_mis++;
    end
    n_cmp++;
    clr_flags = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_flags = 1'b0;
    if (unf_sticky !== 1'b0 || ovf_sticky !== 1'b0) begin $display("FAIL unf_clear got=%b%b exp=00", ovf_sticky, unf_sticky); n_mis++; end
    n_cmp++;
    // Clear held across an erroring op: the set in EXEC must win that edge.
    clr_flags = 1'b1;
    do_op(OP_POP, 8'h00);
    if (r_unf !== 1'b1) begin $display("FAIL set_beats_clr got=%b exp=1", r_unf); n_mis++; end
    n_cmp++;
    if (unf_sticky !== 1'b0) begin $display("FAIL clr_after_set got=%b exp=0", unf_sticky); n_mis++; end
    n_cmp++;
    clr_flags = 1'b0;
  endtask

  task automatic test_replace();
    apply_reset();
    do_op(OP_PUSH, 8'h10);
    do_op(OP_REPLACE, 8'h20);
    if (r_data !== 8'h10 || r_err !== 1'b0 || r_count !== 3'd1) begin
      $display("FAIL replace got d=%h e=%b c=%0d exp 10 0 1", r_data, r_err, r_count); n_mis++;
    end
    n_cmp++;
    do_op(OP_PEEK, 8'h00);
    if (r_data !== 8'h20 || r_err !== 1'b0 || r_count !== 3'd1) begin
      $display("FAIL replace_peek got d=%h e=%b c=%0d exp 20 0 1", r_data, r_err, r_count); n_mis++;
    end
    n_cmp++;
  endtask

  task automatic test_back_pressure();
    apply_reset();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = 8'h11;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      $display("FAIL bp_exec got v=%b r=%b exp 0 0", bus.rsp_valid, bus.cmd_ready); n_mis++;
    end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h11 || bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
        $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b r=%b exp 1 11 0 0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready);
        n_mis++;
      end
      n_cmp++;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || count !== 3'd1) begin
      $display("FAIL bp_release got r=%b v=%b c=%0d exp 1 0 1", bus.cmd_ready, bus.rsp_valid, count); n_mis++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    do_op(OP_PUSH, 8'h01);
    do_op(OP_PUSH, 8'h02);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = 8'h03;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (count !== 3'd0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      $display("FAIL midrst got c=%0d v=%b r=%b exp 0 0 1", count, bus.rsp_valid, bus.cmd_ready); n_mis++;
    end
    n_cmp++;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) begin $display("FAIL midrst_rsp got=%b exp=0", bus.rsp_valid); n_mis++; end
    n_cmp++;
    do_op(OP_PUSH, 8'h07);
    do_op(OP_POP, 8'h00);
    if (r_data !== 8'h07 || r_count !== 3'd0) begin
      $display("FAIL midrst_reuse got d=%h c=%0d exp 07 0", r_data, r_count); n_mis++;
    end
    n_cmp++;
  endtask

  task automatic test_checksum();
`ifdef PARAM_STACK_CHECKSUM_EN
    logic [1:0] ops  [5] = '{OP_PUSH, OP_PUSH, OP_REPLACE, OP_PEEK, OP_POP};
    logic [7:0] din  [5] = '{8'h0F, 8'hF0, 8'h01, 8'h00, 8'h00};
    logic [7:0] cexp [5] = '{8'h0F, 8'hFF, 8'h0E, 8'h0E, 8'h0F};
`else
    logic [1:0] ops  [5] = '{OP_PUSH, OP_PUSH, OP_REPLACE, OP_PEEK, OP_POP};
    logic [7:0] din  [5] = '{8'h0F, 8'hF0, 8'h01, 8'h00, 8'h00};
    logic [7:0] cexp [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], din[i]);
      if (checksum !== cexp[i]) begin
        $display("FAIL checksum[%0d] got=%h exp=%h", i, checksum, cexp[i]); n_mis++;
      end
      n_cmp++;
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_push_pop();
    test_full();
    test_underflow();
    test_replace();
    test_back_pressure();
    test_reset_mid_op();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
